key_event_ctrl: RTL and testbench
=================================

// Module: key_event_ctrl
// PURPOSE
//  Parametrised multi-key front end replacing per-key debounce instances in the
//  DE2_115 top. Synchronises and debounces NUM_KEYS raw active-low push buttons.
//  Emits per-key press, release and long-press pulses, plus auto-repeat pulses
//  when the optional feature is compiled in. Outputs feed the Top recorder
//  control keys (record/play/stop) in the CLK_12M domain.
// PARAMETERS
//  NUM_KEYS       4          number of independent key channels
//  DEB_CYCLES     60000      consecutive stable cycles needed to accept a level change (>=2)
//  LONG_CYCLES    6000000    cycles after o_press before o_long fires (>DEB_CYCLES)
//  REPEAT_CYCLES  1200000    auto-repeat period after o_long (>=2)
//  CNT_W          24         counter width; must hold max(DEB,LONG,REPEAT)_CYCLES
// PORTS
//  i_clk      in   1         system clock (CLK_12M)
//  i_rst_n    in   1         asynchronous active-low reset
//  i_keys     in   NUM_KEYS  raw buttons, active-low, asynchronous to i_clk
//  o_level    out  NUM_KEYS  debounced state, 1 = pressed
//  o_press    out  NUM_KEYS  1-cycle pulse on accepted press
//  o_release  out  NUM_KEYS  1-cycle pulse on accepted release
//  o_long     out  NUM_KEYS  1-cycle pulse, once per hold, at LONG_CYCLES
//  o_repeat   out  NUM_KEYS  1-cycle auto-repeat pulse (0 without KEY_REPEAT_EN)
//  o_any      out  1         OR of o_level
// BEHAVIOUR
//  - Reset: sync FFs = 1 (released), all counters 0, all FSMs IDLE, every output 0.
//  - Per key: 2-FF synchroniser, then debounce counter, then FSM; keys fully independent.
//  - Debounce: counter increments while sync value != accepted level, clears to 0
//    the cycle they agree. At count == DEB_CYCLES-1 the level flips and counter clears.
//    Glitches shorter than DEB_CYCLES produce no output.
//  - Latency: raw edge -> o_level/o_press (or o_release) = 2 + DEB_CYCLES cycles.
//    o_level and its pulse change on the same clock edge (registered outputs).
//  - FSM states: IDLE (released) -> HELD on accepted press (o_press=1).
//    HELD: hold counter counts from 0. At LONG_CYCLES-1 -> LONG (o_long=1), counter clears.
//    LONG: with KEY_REPEAT_EN, o_repeat=1 each time counter hits REPEAT_CYCLES-1, then wraps.
//    HELD/LONG -> IDLE on accepted release (o_release=1); hold counter cleared.
//  - Release before LONG_CYCLES: no o_long. o_long fires at most once per hold.
//  - Hold counter saturates in HELD. It never wraps past the compare value.
//  - Simultaneous events on different keys: all pulses asserted in the same cycle.
//  - Press/release pulse cannot coincide with o_long/o_repeat on the same key.
//    An accepted release pre-empts a repeat due in that cycle.
//  - Reset mid-operation: immediate return to reset values. A key held through reset
//    is reported as a new press 2+DEB_CYCLES cycles after i_rst_n deasserts.
// CONFIGURATION
//  KEY_REPEAT_EN defined: LONG state generates periodic o_repeat as above.
//  Not defined: o_repeat tied to 0 and repeat logic absent. LONG only waits for release.
// TESTING (DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8, NUM_KEYS=4)
//  1. Reset, i_keys=4'hF -> all outputs 0. i_keys[0]=0 held -> o_press[0]=1 exactly 6
//     cycles after the edge, o_level[0]=1, o_any=1.
//  2. Pulse i_keys[1]=0 for 3 cycles -> no o_press[1], o_level[1] stays 0.
//     Bounce 0/1 every 2 cycles for 20 cycles, then hold 0 -> single o_press[1].
//  3. Hold key 2 for 40 cycles after o_press -> o_long[2] 20 cycles after o_press.
//     With KEY_REPEAT_EN: o_repeat[2] at +8 and +16 after o_long. Without: o_repeat=0.
//     Release -> one o_release[2] 6 cycles after the release edge.
//  4. Press keys 0 and 3 on the same edge -> o_press=4'b1001 in one cycle.
//     Release key 0 after 10 cycles -> o_release[0] and no o_long[0].
//  5. Assert i_rst_n=0 while key 1 is in LONG -> outputs 0 immediately.
//     Key still held at deassert -> o_press[1] 6 cycles later.

Source files
------------

// File: rtl/key_event_ctrl.sv
// rtl/key_event_ctrl.sv - per-key sync, debounce and press/release/long/repeat events
// Auto-repeat pulses are built only when KEY_REPEAT_EN is defined.
module key_event_ctrl #(
  parameter int NUM_KEYS      = 4,
  parameter int DEB_CYCLES    = 60000,
  parameter int LONG_CYCLES   = 6000000,
  parameter int REPEAT_CYCLES = 1200000,
  parameter int CNT_W         = 24
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [NUM_KEYS-1:0] i_keys,
  output logic [NUM_KEYS-1:0] o_level,
  output logic [NUM_KEYS-1:0] o_press,
  output logic [NUM_KEYS-1:0] o_release,
  output logic [NUM_KEYS-1:0] o_long,
  output logic [NUM_KEYS-1:0] o_repeat,
  output logic                o_any
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  if (DEB_CYCLES < 2) begin : g_deb_range_err
    $error("DEB_CYCLES must be at least 2");
  end
  if (LONG_CYCLES <= DEB_CYCLES) begin : g_long_range_err
    $error("LONG_CYCLES must exceed DEB_CYCLES");
  end
  if (REPEAT_CYCLES < 2) begin : g_rep_range_err
    $error("REPEAT_CYCLES must be at least 2");
  end

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic             sync_a, sync_b, level;
    logic             flip, rise, fall;
    logic [CNT_W-1:0] deb_cnt, hold_cnt, hold_cnt_nxt;
    state_t           state, state_nxt;
    logic             press_q, release_q, long_q;
    logic             press_nxt, release_nxt, long_nxt;

    // sync_b is still active-low, so equality with level means disagreement
    assign flip = (sync_b == level) && (deb_cnt == DEB_LAST);
    assign rise = flip & ~level;
    assign fall = flip & level;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        sync_a  <= 1'b1;
        sync_b  <= 1'b1;
        deb_cnt <= '0;
        level   <= 1'b0;
      end else begin
        sync_a <= i_keys[k];
        sync_b <= sync_a;
        if (sync_b != level) begin
          deb_cnt <= '0;
        end else if (flip) begin
          deb_cnt <= '0;
          level   <= ~level;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end
    end

`ifdef KEY_REPEAT_EN
    logic repeat_q, repeat_nxt;
`endif

    always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      press_nxt    = 1'b0;
      release_nxt  = 1'b0;
      long_nxt     = 1'b0;
`ifdef KEY_REPEAT_EN
      repeat_nxt   = 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (rise) begin
            state_nxt    = ST_HELD;
            hold_cnt_nxt = '0;
            press_nxt    = 1'b1;
          end
        end
        ST_HELD: begin
          if (fall) begin
            state_nxt    = ST_IDLE;
            hold_cnt_nxt = '0;
            release_nxt  = 1'b1;
          end else if (hold_cnt == LONG_LAST) begin
            state_nxt    = ST_LONG;
            hold_cnt_nxt = '0;
            long_nxt     = 1'b1;
          end else begin
            hold_cnt_nxt = hold_cnt + 1'b1;
          end
        end
        ST_LONG: begin
          // a release wins over a repeat falling due on the same cycle
          if (fall) begin
            state_nxt    = ST_IDLE;
            hold_cnt_nxt = '0;
            release_nxt  = 1'b1;
          end
`ifdef KEY_REPEAT_EN
          else if (hold_cnt == REP_LAST) begin
            hold_cnt_nxt = '0;
            repeat_nxt   = 1'b1;
          end else begin
            hold_cnt_nxt = hold_cnt + 1'b1;
          end
`endif
        end
        default: begin
          state_nxt    = ST_IDLE;
          hold_cnt_nxt = '0;
        end
      endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state     <= ST_IDLE;
        hold_cnt  <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
`ifdef KEY_REPEAT_EN
        repeat_q  <= 1'b0;
`endif
      end else begin
        state     <= state_nxt;
        hold_cnt  <= hold_cnt_nxt;
        press_q   <= press_nxt;
        release_q <= release_nxt;
        long_q    <= long_nxt;
`ifdef KEY_REPEAT_EN
        repeat_q  <= repeat_nxt;
`endif
      end
    end

    assign o_level[k]   = level;
    assign o_press[k]   = press_q;
    assign o_release[k] = release_q;
    assign o_long[k]    = long_q;
`ifdef KEY_REPEAT_EN
    assign o_repeat[k]  = repeat_q;
`endif
  end

`ifndef KEY_REPEAT_EN
  assign o_repeat = '0;
`endif

  assign o_any = |o_level;

endmodule

// File: tb/tb_key_event_ctrl.sv
// tb/tb_key_event_ctrl.sv - directed and randomized checks of key_event_ctrl against a window/age model
module tb_key_event_ctrl;

  localparam int NK   = 4;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] keys = 4'hF;
  logic [NK-1:0] level, press, release_p, long_p, repeat_p;
  logic          any;

  int tests_run = 0;
  int tests_failed = 0;

  key_event_ctrl #(
    .NUM_KEYS(NK), .DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .CNT_W(24)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_keys(keys),
    .o_level(level), .o_press(press), .o_release(release_p),
    .o_long(long_p), .o_repeat(repeat_p), .o_any(any)
  );

  always #5 clk = ~clk;

  // model: last 6 raw samples per key (bit0 newest) and hold age since press
  logic [5:0]    win [NK];
  int            age [NK];
  logic [NK-1:0] m_level, m_press, m_release, m_long, m_repeat;

  function automatic void model_reset();
    for (int k = 0; k < NK; k++) begin
      win[k] = 6'h3F;
      age[k] = 0;
    end
    m_level = '0; m_press = '0; m_release = '0; m_long = '0; m_repeat = '0;
  endfunction

  function automatic void model_step(input logic [NK-1:0] kv);
    for (int k = 0; k < NK; k++) begin
      win[k] = {win[k][4:0], kv[k]};
      m_press[k] = 1'b0; m_release[k] = 1'b0; m_long[k] = 1'b0; m_repeat[k] = 1'b0;
      // samples 2..5 are the last DEB values seen through the 2-stage synchroniser
      if (!m_level[k] && win[k][5:2] == 4'b0000) begin
        m_level[k] = 1'b1; m_press[k] = 1'b1; age[k] = 0;
      end else if (m_level[k] && win[k][5:2] == 4'b1111) begin
        m_level[k] = 1'b0; m_release[k] = 1'b1;
      end else if (m_level[k]) begin
        age[k]++;
        if (age[k] == LONG) m_long[k] = 1'b1;
`ifdef KEY_REPEAT_EN
        else if (age[k] > LONG && (age[k] - LONG) % REP == 0) m_repeat[k] = 1'b1;
`endif
      end
    end
  endfunction

  function automatic logic [20:0] exp_vec();
    return {m_level, m_press, m_release, m_long, m_repeat, |m_level};
  endfunction

  function automatic logic [20:0] dut_vec();
    return {level, press, release_p, long_p, repeat_p, any};
  endfunction

  task automatic tick(input logic [NK-1:0] kv);
    keys = kv;
    @(posedge clk);
    model_step(kv);
    #1;
  endtask

  task automatic settle(input int n);
    repeat (n) tick(4'hF);
  endtask

  task automatic test_reset();
    keys = 4'hF;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (dut_vec() !== 21'h0) begin
      tests_failed++;
      $display("FAIL reset_hold: got %h want 0", dut_vec());
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick(4'hF);
      tests_run++;
      if (dut_vec() !== 21'h0) begin
        tests_failed++;
        $display("FAIL reset_idle cycle %0d: got %h want 0", c, dut_vec());
      end
    end
  endtask

  task automatic test_press_latency();
    for (int c = 1; c <= 8; c++) begin
      tick(4'b1110);
      tests_run++;
      if (dut_vec() !== exp_vec() || press[0] !== (c == 6)) begin
        tests_failed++;
        $display("FAIL press_latency cycle %0d: got %h want %h press0=%b", c, dut_vec(), exp_vec(), press[0]);
      end
    end
    tests_run++;
    if (level[0] !== 1'b1 || any !== 1'b1) begin
      tests_failed++;
      $display("FAIL press_level: level0=%b any=%b want 1 1", level[0], any);
    end
  endtask

  task automatic test_glitch();
    int presses;
    settle(30);
    for (int c = 1; c <= 13; c++) begin
      tick(c <= 3 ? 4'b1101 : 4'b1111);
      tests_run++;
      if (dut_vec() !== exp_vec() || press[1] !== 1'b0 || level[1] !== 1'b0) begin
        tests_failed++;
        $display("FAIL glitch cycle %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
    presses = 0;
    for (int c = 0; c < 32; c++) begin
      tick((c < 20 && ((c / 2) % 2 == 1)) ? 4'b1111 : 4'b1101);
      if (press[1]) presses++;
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL bounce cycle %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
    tests_run++;
    if (presses !== 1) begin
      tests_failed++;
      $display("FAIL bounce_presses: got %0d want 1", presses);
    end
  endtask

  task automatic test_long_repeat();
    int p, l, r1, r2, nrep, nrel, rc, want_rep;
    p = -1; l = -1; r1 = -1; r2 = -1; nrep = 0; nrel = 0; rc = -1;
    settle(30);
    for (int c = 1; c <= 46; c++) begin
      tick(4'b1011);
      if (press[2]) p = c;
      if (long_p[2]) l = c;
      if (repeat_p[2]) begin
        nrep++;
        if (r1 < 0) r1 = c; else r2 = c;
      end
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL long_hold cycle %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
    tests_run++;
    if (p !== 6 || l !== 26) begin
      tests_failed++;
      $display("FAIL long_timing: press at %0d long at %0d want 6 26", p, l);
    end
`ifdef KEY_REPEAT_EN
    want_rep = 2;
    tests_run++;
    if (r1 !== l + 8 || r2 !== l + 16) begin
      tests_failed++;
      $display("FAIL repeat_timing: got %0d %0d want %0d %0d", r1, r2, l + 8, l + 16);
    end
`else
    want_rep = 0;
`endif
    tests_run++;
    if (nrep !== want_rep) begin
      tests_failed++;
      $display("FAIL repeat_count: got %0d want %0d", nrep, want_rep);
    end
    for (int c = 1; c <= 10; c++) begin
      tick(4'hF);
      if (release_p[2]) begin nrel++; rc = c; end
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL long_release cycle %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
    tests_run++;
    if (nrel !== 1 || rc !== 6) begin
      tests_failed++;
      $display("FAIL release_timing: count %0d at %0d want 1 at 6", nrel, rc);
    end
  endtask

  task automatic test_simultaneous();
    int nlong0;
    nlong0 = 0;
    settle(30);
    for (int c = 1; c <= 10; c++) begin
      tick(4'b0110);
      tests_run++;
      if (dut_vec() !== exp_vec() || press !== ((c == 6) ? 4'b1001 : 4'b0000)) begin
        tests_failed++;
        $display("FAIL simul_press cycle %0d: press %b got %h want %h", c, press, dut_vec(), exp_vec());
      end
    end
    for (int c = 1; c <= 30; c++) begin
      tick(4'b0111);
      if (long_p[0]) nlong0++;
      tests_run++;
      if (dut_vec() !== exp_vec() || release_p[0] !== (c == 6)) begin
        tests_failed++;
        $display("FAIL simul_release cycle %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
    tests_run++;
    if (nlong0 !== 0) begin
      tests_failed++;
      $display("FAIL short_hold_long: got %0d long pulses want 0", nlong0);
    end
  endtask

  task automatic test_reset_mid();
    settle(30);
    for (int c = 1; c <= 30; c++) begin
      tick(4'b1101);
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL pre_reset_hold cycle %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if (dut_vec() !== 21'h0) begin
      tests_failed++;
      $display("FAIL reset_mid: got %h want 0", dut_vec());
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick(4'b1101);
      tests_run++;
      if (dut_vec() !== exp_vec() || press[1] !== (c == 6)) begin
        tests_failed++;
        $display("FAIL reset_repress cycle %0d: got %h want %h", c, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [NK-1:0] kv;
    int run [NK];
    kv = 4'hF;
    for (int k = 0; k < NK; k++) run[k] = $urandom_range(1, 10);
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        run[k]--;
        if (run[k] <= 0) begin
          kv[k] = ~kv[k];
          run[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 70) : $urandom_range(1, 8);
        end
      end
      tick(kv);
      tests_run++;
      if (dut_vec() !== exp_vec()) begin
        tests_failed++;
        $display("FAIL random cycle %0d keys %b: got %h want %h", c, kv, dut_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_press_latency();
    test_glitch();
    test_long_repeat();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
